// File: rtl/fpsub_pipe.sv
// FP32 subtractor (A - B), truncating, for normal operands only.
// Register chain: unpack -> compare/align -> add/normalize -> packed output; one global advance enable.
module fpsub_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    // Every register advances together; a stalled output freezes the whole chain.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        lzc24 = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) lzc24 = 5'(23 - i);
        end
    endfunction

    // Stage 1: unpack, with B's sign already negated.
    logic        s1_valid, s1_sa, s1_sb;
    logic [7:0]  s1_ea, s1_eb;
    logic [23:0] s1_ma, s1_mb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_ea    <= '0;
            s1_eb    <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_sa    <= reg_A[31];
            s1_sb    <= ~reg_B[31];
            s1_ea    <= reg_A[30:23];
            s1_eb    <= reg_B[30:23];
            s1_ma    <= {1'b1, reg_A[22:0]};
            s1_mb    <= {1'b1, reg_B[22:0]};
        end
    end

    // Stage 2: pick the larger magnitude and align the smaller one.
    logic        a_big;
    logic [7:0]  big_e, small_e, exp_diff;
    logic [23:0] big_m, small_m, small_al;

    always_comb begin
        a_big    = {s1_ea, s1_ma} >= {s1_eb, s1_mb};
        big_e    = a_big ? s1_ea : s1_eb;
        small_e  = a_big ? s1_eb : s1_ea;
        big_m    = a_big ? s1_ma : s1_mb;
        small_m  = a_big ? s1_mb : s1_ma;
        exp_diff = big_e - small_e;
        small_al = (exp_diff >= 8'd24) ? 24'd0 : (small_m >> exp_diff);
    end

    logic        s2_valid, s2_sign, s2_sub;
    logic [7:0]  s2_exp;
    logic [23:0] s2_mbig, s2_msmall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_sub    <= 1'b0;
            s2_exp    <= '0;
            s2_mbig   <= '0;
            s2_msmall <= '0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_sign   <= a_big ? s1_sa : s1_sb;
            s2_sub    <= s1_sa ^ s1_sb;
            s2_exp    <= big_e;
            s2_mbig   <= big_m;
            s2_msmall <= small_al;
        end
    end

    // Stage 3: add or subtract magnitudes, then renormalize.
    logic [24:0] sum25;
    logic [23:0] diff24, norm24, mant24;
    logic [4:0]  lz;
    logic [7:0]  exp_n;
    logic        is_zero;

    always_comb begin
        sum25   = {1'b0, s2_mbig} + {1'b0, s2_msmall};
        diff24  = s2_mbig - s2_msmall;
        lz      = lzc24(diff24);
        norm24  = diff24 << lz;
        is_zero = 1'b0;
        if (!s2_sub) begin
            if (sum25[24]) begin
                mant24 = sum25[24:1];
                exp_n  = s2_exp + 8'd1;
            end else begin
                mant24 = sum25[23:0];
                exp_n  = s2_exp;
            end
        end else begin
            mant24  = norm24;
            exp_n   = s2_exp - {3'b000, lz};
            is_zero = (diff24 == 24'd0);
        end
    end

    logic        s3_valid, s3_zero, s3_sign;
    logic [7:0]  s3_exp;
    logic [22:0] s3_mant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_zero  <= 1'b0;
            s3_sign  <= 1'b0;
            s3_exp   <= '0;
            s3_mant  <= '0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            s3_zero  <= is_zero;
            s3_sign  <= s2_sign;
            s3_exp   <= exp_n;
            s3_mant  <= mant24[22:0];
        end
    end

    // Exact cancellation is always +0, whatever the operand signs were.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= 32'h0000_0000;
        end else if (adv) begin
            out_valid <= s3_valid;
            out       <= s3_zero ? 32'h0000_0000 : {s3_sign, s3_exp, s3_mant};
        end
    end

endmodule

// File: tb/tb_fpsub_pipe.sv
// Scoreboard bench for fpsub_pipe: driver pushes expected results, a negedge monitor pops and compares.
// Reference model works on integer mantissas scaled by the larger exponent.
module tb_fpsub_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] reg_A, reg_B;
    logic        out_valid, out_ready;
    logic [31:0] out;

    fpsub_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .reg_A    (reg_A),
        .reg_B    (reg_B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          lat_mode = 1'b0;
    bit          rnd_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_out = '0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, ebig, esm, d, e;
        longint ma, mb, mbig, msm, r;
        bit     sa, sbn, a_big, sbig;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        sa = a[31];
        sbn = ~b[31];
        a_big = (ea > eb) || (ea == eb && ma >= mb);
        ebig = a_big ? ea : eb;
        esm  = a_big ? eb : ea;
        mbig = a_big ? ma : mb;
        msm  = a_big ? mb : ma;
        sbig = a_big ? sa : sbn;
        d = ebig - esm;
        if (d >= 24) msm = 0;
        else msm = msm >> d;
        r = (sa == sbn) ? mbig + msm : mbig - msm;
        if (r == 0) return 32'h0000_0000;
        e = ebig;
        while (r >= (64'd1 << 24)) begin r = r >> 1; e++; end
        while (r < (64'd1 << 23)) begin r = r << 1; e--; end
        return {sbig, 8'(e), 23'(r)};
    endfunction

    // Monitor: all sampling on the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || out !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold: out_valid=%0b out=%h, required out_valid=1 out=%h", out_valid, out, prev_out);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_stall: in_ready=%0b, required 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: out=%h with no pending result", out);
                end else begin
                    e = sb.pop_front();
                    if (out !== e.val) begin
                        errors++;
                        $display("FAIL result: out=%h, required %h", out, e.val);
                    end
                    if (lat_mode) begin
                        checks++;
                        if (cyc - e.acc != 3) begin
                            errors++;
                            $display("FAIL latency: %0d edges, required 3", cyc - e.acc);
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int tries = 0;
        bit done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            reg_A     = a;
            reg_B     = b;
            out_ready = rnd_ready ? 1'($urandom) : 1'b1;
            #1;
            if (in_ready) begin
                sb.push_back('{expv, cyc + 1});
                done = 1'b1;
            end else if (++tries > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stuck at 0");
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results pending, required 0", sb.size());
        end
        idle(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (out_valid !== 1'b0 || out !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: out_valid=%0b out=%h in_ready=%0b, required 0 00000000 1", tag, out_valid, out, in_ready);
        end
    endtask

    task automatic send_rand();
        int ea, eb;
        logic [31:0] a, b;
        ea = int'($urandom_range(110, 140));
        case ($urandom_range(0, 3))
            0: eb = ea;
            1: eb = ea + int'($urandom_range(0, 6)) - 3;
            2: eb = int'($urandom_range(100, 150));
            default: eb = ea;
        endcase
        a = {1'($urandom), 8'(ea), 23'($urandom)};
        b = {1'($urandom), 8'(eb), 23'($urandom)};
        if ($urandom_range(0, 3) == 0) b[22:0] = a[22:0] ^ 23'($urandom_range(0, 15));
        send(a, b, model(a, b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; reg_A = '0; reg_B = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b0;

        // Directed vectors with constant expected results and latency checking.
        lat_mode = 1'b1;
        send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
        send(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
        send(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000);
        send(32'h3FC0_0000, 32'h3FA0_0000, 32'h3E80_0000);
        send(32'hC000_0000, 32'h3F80_0000, 32'hC040_0000);
        send(32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000);
        send(32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000);
        drain();

        // Reset with three pairs in flight.
        send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
        send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
        send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_midflight");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(8);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset: out_valid=%0b, required 0", out_valid);
        end
        send(32'h3FC0_0000, 32'h3FA0_0000, 32'h3E80_0000);
        drain();
        lat_mode = 1'b0;

        // Randomized pairs with pseudo-random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_rand();
        for (int i = 0; i < 60; i++) begin
            send_rand();
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
                in_valid  = 1'b0;
                out_ready = 1'($urandom);
            end
        end
        rnd_ready = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpsub_pipe.md
FPSUB_PIPE -- requirements
Module: fpsub_pipe

Interface
REQ-001 The block SHALL have no parameters; operand and result width are fixed at 32 bits (FP32: 1 sign, 8 exponent biased by 127, 23 mantissa).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair on reg_A/reg_B is valid this cycle.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 reg_A  input  32  minuend, FP32.
REQ-007 reg_B  input  32  subtrahend, FP32.
REQ-008 out_valid  output  1  out holds a valid result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 out  output  32  FP32 result A - B.

Function
REQ-011 The block SHALL compute out = A - B for normal FP32 inputs (0 < exp < 255); NaN, infinity, subnormal inputs and result overflow/underflow are out of scope and unchecked.
REQ-012 Effective operation: negate sign of B, then add signed magnitudes.
REQ-013 Magnitude compare: larger exponent wins; on equal exponents, larger 24-bit mantissa (hidden 1 prepended) wins; result sign = effective sign of the larger-magnitude operand.
REQ-014 Alignment: smaller mantissa shifted right by exponent difference, shifted-out bits discarded (truncation, no guard/round/sticky); difference >= 24 makes smaller contribution 0.
REQ-015 Equal effective signs: 25-bit mantissa sum; if bit 24 set, shift right 1 and exponent +1, truncating.
REQ-016 Opposite effective signs: larger minus smaller mantissa; normalize left by leading-zero count of the 24-bit difference, exponent reduced by that count.
REQ-017 Zero difference SHALL produce exactly 32'h00000000 (+0), regardless of operand signs.
REQ-018 Pipeline: 3 stages -- S1 register operands and unpack, S2 compare/align, S3 add/subtract, normalize, pack into out register.
REQ-019 An operand pair is accepted when in_valid && in_ready at a rising edge.
REQ-020 With out_ready held high, the result for a pair accepted at edge N SHALL appear with out_valid=1 after edge N+3 (latency 3); throughput one pair per cycle.
REQ-021 A result is consumed when out_valid && out_ready at a rising edge.
REQ-022 Stall: when out_valid=1 and out_ready=0, all stages SHALL hold, out and out_valid SHALL stay stable, and in_ready SHALL be 0.
REQ-023 in_ready = !out_valid || out_ready (combinational); bubbles (invalid stages) SHALL advance during stall only if this rule permits, no pair SHALL be dropped or duplicated.
REQ-024 Results SHALL emerge in acceptance order; each stage carries its own valid bit.
REQ-025 Simultaneous consume at output and accept at input in the same cycle SHALL be supported with no bubble.

Reset
REQ-026 While reset=1: all stage valid bits 0, out = 32'h00000000, out_valid = 0, in_ready = 1, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight pairs; no result from before reset SHALL appear afterwards.
REQ-028 First acceptance possible on the first rising edge after reset deasserts.

Verification
REQ-029 A=0x40400000 (3.0), B=0x3F800000 (1.0), out_ready=1 -> out=0x40000000 (2.0), out_valid exactly 3 edges after acceptance.
REQ-030 A=0x3F800000, B=0x3F800000 -> out=0x00000000; A=0x3F800000, B=0xBF800000 -> out=0x40000000 (carry path).
REQ-031 A=0x3FC00000 (1.5), B=0x3FA00000 (1.25) -> out=0x3E800000 (0.25, left-normalize by 2); A=0xC0000000 (-2.0), B=0x3F800000 -> out=0xC0400000 (-3.0).
REQ-032 A=0x3F800000, B=0x30800000 (2^-30) -> out=0x3F800000 (shift >= 24 contributes 0).
REQ-033 Back-to-back 6 pairs with out_ready toggling pseudo-randomly -> all 6 results in order, out stable during stalls, in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-034 Assert reset with 3 pairs in flight -> out_valid=0, out=0 immediately; after release no stale result appears.
